// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/acknowledge data-bus bundle between the MEM-stage
// access unit (master) and a variable-latency memory (slave).
//   bus_req   master->slave  access request, held until bus_ack
//   bus_we    master->slave  1 = write
//   bus_addr  master->slave  word-aligned byte address
//   bus_be    master->slave  byte-lane enables
//   bus_wdata master->slave  lane-positioned write data
//   bus_ack   slave->master  write accepted / read data valid this cycle
//   bus_rdata slave->master  read data, valid with bus_ack
interface mem_access_unit_if #(
    parameter int unsigned W = 32
);
    localparam int unsigned BYTES = W / 8;

    logic             bus_req;
    logic             bus_we;
    logic [W-1:0]     bus_addr;
    logic [BYTES-1:0] bus_be;
    logic [W-1:0]     bus_wdata;
    logic             bus_ack;
    logic [W-1:0]     bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit. Takes one request from the
// pipeline, aligns store data / byte enables onto the bus lanes, waits for
// bus_ack (any number of wait states) and returns extended load data.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_write   request strobe, 1 = store
//   req_addr, req_wdata   byte address, right-justified store data
//   l_s_mode              0 WORD, 1 HALF, 2 HALF_U, 3 BYTE, 4 BYTE_U (5-7 invalid)
//   stall                 combinational pipeline hold
//   done                  one-cycle completion pulse
//   rdata                 extended load data, held until the next load
//   misalign              combinational alignment fault (0 unless check build)
//   bus                   master side of mem_access_unit_if
// Build option: define MEM_ALIGN_CHECK_EN to reject misaligned HALF/WORD requests.
module mem_access_unit #(
    parameter int unsigned W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [W-1:0]      req_addr,
    input  logic [2:0]        l_s_mode,
    input  logic [W-1:0]      req_wdata,
    output logic              stall,
    output logic              done,
    output logic [W-1:0]      rdata,
    output logic              misalign,
    mem_access_unit_if.master bus
);
    localparam int unsigned BYTES = W / 8;
    localparam int unsigned OFFW  = $clog2(BYTES);
    localparam int unsigned SHW   = OFFW + 3;

    localparam logic [2:0] MODE_WORD   = 3'd0;
    localparam logic [2:0] MODE_HALF   = 3'd1;
    localparam logic [2:0] MODE_HALF_U = 3'd2;
    localparam logic [2:0] MODE_BYTE   = 3'd3;
    localparam logic [2:0] MODE_BYTE_U = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [OFFW-1:0]  off;
    logic             mode_valid;
    logic             fault;
    logic             accept;
    logic [BYTES-1:0] be_c;
    logic [SHW-1:0]   wsh;
    logic [W-1:0]     lane_mask;
    logic [W-1:0]     wdata_c;
    logic [OFFW-1:0]  off_q;
    logic [2:0]       mode_q;
    logic [SHW-1:0]   rsh;
    logic [W-1:0]     rshift;
    logic [W-1:0]     ext;

    assign off        = req_addr[OFFW-1:0];
    assign mode_valid = (l_s_mode <= MODE_BYTE_U);

`ifdef MEM_ALIGN_CHECK_EN
    // Halves need an even offset, words a zero offset; bytes never fault.
    always_comb begin
        fault = 1'b0;
        case (l_s_mode)
            MODE_HALF, MODE_HALF_U: fault = off[0];
            MODE_WORD:              fault = (off != '0);
            default:                fault = 1'b0;
        endcase
    end
`else
    assign fault = 1'b0;
`endif

    assign misalign = (state_q == S_IDLE) && req_valid && fault;
    assign accept   = (state_q == S_IDLE) && req_valid && mode_valid && !fault;
    assign stall    = accept || (state_q == S_BUS);

    // Byte enables and store-data lane placement; WORD ignores the offset.
    always_comb begin
        be_c      = '0;
        wsh       = '0;
        lane_mask = '0;
        case (l_s_mode)
            MODE_WORD: be_c = '1;
            MODE_HALF, MODE_HALF_U: begin
                be_c = BYTES'(3) << off;
                wsh  = {off, 3'b000};
            end
            MODE_BYTE, MODE_BYTE_U: begin
                be_c = BYTES'(1) << off;
                wsh  = {off, 3'b000};
            end
            default: ;
        endcase
        for (int unsigned i = 0; i < BYTES; i++) begin
            lane_mask[i*8 +: 8] = {8{be_c[i]}};
        end
        wdata_c = (req_wdata << wsh) & lane_mask;
    end

    // Load data: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        rsh    = (mode_q == MODE_WORD) ? '0 : {off_q, 3'b000};
        rshift = bus.bus_rdata >> rsh;
        case (mode_q)
            MODE_HALF:   ext = W'($signed(rshift[15:0]));
            MODE_HALF_U: ext = W'(rshift[15:0]);
            MODE_BYTE:   ext = W'($signed(rshift[7:0]));
            MODE_BYTE_U: ext = W'(rshift[7:0]);
            default:     ext = rshift;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_BUS;
            S_BUS:   if (bus.bus_ack) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs and request capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_be    <= '0;
            bus.bus_wdata <= '0;
            done          <= 1'b0;
            rdata         <= '0;
            off_q         <= '0;
            mode_q        <= MODE_WORD;
        end else begin
            bus.bus_req <= (state_d == S_BUS);
            done        <= (state_d == S_DONE);
            if (accept) begin
                bus.bus_we    <= req_write;
                bus.bus_addr  <= req_addr & ~W'(BYTES - 1);
                bus.bus_be    <= be_c;
                bus.bus_wdata <= wdata_c;
                off_q         <= off;
                mode_q        <= l_s_mode;
            end
            if ((state_q == S_BUS) && bus.bus_ack && !bus.bus_we) begin
                rdata <= ext;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed bench for mem_access_unit (W=32 and W=64 instances).
module tb_mem_access_unit;
    localparam logic [2:0] M_WORD   = 3'd0;
    localparam logic [2:0] M_HALF   = 3'd1;
    localparam logic [2:0] M_BYTE   = 3'd3;
    localparam logic [2:0] M_BYTE_U = 3'd4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  l_s_mode;
    logic        stall, done, misalign;
    logic [31:0] rdata;

    logic        v64, w64, stall64, done64, mis64;
    logic [63:0] a64, wd64, rd64;
    logic [2:0]  m64;

    mem_access_unit_if #(.W(32)) bus32 ();
    mem_access_unit_if #(.W(64)) bus64 ();

    mem_access_unit #(.W(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .l_s_mode(l_s_mode), .req_wdata(req_wdata),
        .stall(stall), .done(done), .rdata(rdata), .misalign(misalign), .bus(bus32)
    );

    mem_access_unit #(.W(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .req_valid(v64), .req_write(w64),
        .req_addr(a64), .l_s_mode(m64), .req_wdata(wd64),
        .stall(stall64), .done(done64), .rdata(rd64), .misalign(mis64), .bus(bus64)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Observations recorded by do_access.
    logic        o_stall_c0, o_mis_c0, o_req, o_we, o_stable, o_done, o_stall_done, o_done_after;
    logic [31:0] o_addr, o_wdata, o_rdata;
    logic [3:0]  o_be;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Runs one access on the W=32 unit: accept in C0, ack after 'waits' idle bus cycles.
    task automatic do_access(input logic w, input logic [31:0] addr, input logic [2:0] mode,
                             input logic [31:0] wd, input int waits, input logic [31:0] rd);
        req_valid = 1'b1; req_write = w; req_addr = addr; l_s_mode = mode; req_wdata = wd;
        @(negedge clk);
        o_stall_c0 = stall;
        o_mis_c0   = misalign;
        next_cycle();
        o_req = bus32.bus_req; o_we = bus32.bus_we; o_addr = bus32.bus_addr;
        o_be = bus32.bus_be; o_wdata = bus32.bus_wdata;
        o_stable = 1'b1;
        for (int i = 0; i <= waits; i++) begin
            bus32.bus_ack   = (i == waits);
            bus32.bus_rdata = (i == waits) ? rd : 32'h5A5A_5A5A;
            @(negedge clk);
            if (stall !== 1'b1 || bus32.bus_req !== 1'b1 || bus32.bus_we !== o_we ||
                bus32.bus_addr !== o_addr || bus32.bus_be !== o_be ||
                bus32.bus_wdata !== o_wdata || done !== 1'b0)
                o_stable = 1'b0;
            next_cycle();
        end
        bus32.bus_ack = 1'b0;
        req_valid = 1'b0;
        o_done  = done;
        o_rdata = rdata;
        @(negedge clk);
        o_stall_done = stall;
        next_cycle();
        o_done_after = done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        n_tests++; if (stall !== 1'b0 || done !== 1'b0 || misalign !== 1'b0) begin n_fail++;
            $display("FAIL reset_ctl: stall=%b done=%b misalign=%b want 000", stall, done, misalign); end
        n_tests++; if (bus32.bus_req !== 1'b0 || bus32.bus_we !== 1'b0) begin n_fail++;
            $display("FAIL reset_bus_req_we: req=%b we=%b want 00", bus32.bus_req, bus32.bus_we); end
        n_tests++; if (bus32.bus_addr !== 32'h0 || bus32.bus_be !== 4'h0 || bus32.bus_wdata !== 32'h0) begin n_fail++;
            $display("FAIL reset_bus_data: addr=%h be=%h wdata=%h want 0", bus32.bus_addr, bus32.bus_be, bus32.bus_wdata); end
        n_tests++; if (rdata !== 32'h0) begin n_fail++;
            $display("FAIL reset_rdata: got %h want 0", rdata); end
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_word_load();
        do_access(1'b0, 32'h100, M_WORD, 32'h0, 0, 32'hDEAD_BEEF);
        n_tests++; if (o_stall_c0 !== 1'b1 || o_req !== 1'b1) begin n_fail++;
            $display("FAIL word_stall_c0_req_c1: stall=%b req=%b want 11", o_stall_c0, o_req); end
        n_tests++; if (o_addr !== 32'h100 || o_be !== 4'hF || o_we !== 1'b0) begin n_fail++;
            $display("FAIL word_bus: addr=%h be=%h we=%b want 100 f 0", o_addr, o_be, o_we); end
        n_tests++; if (o_stable !== 1'b1) begin n_fail++;
            $display("FAIL word_stall_c1: stable=%b want 1", o_stable); end
        n_tests++; if (o_done !== 1'b1 || o_rdata !== 32'hDEAD_BEEF) begin n_fail++;
            $display("FAIL word_done_c2: done=%b rdata=%h want 1 deadbeef", o_done, o_rdata); end
        n_tests++; if (o_stall_done !== 1'b0 || o_done_after !== 1'b0) begin n_fail++;
            $display("FAIL word_after: stall_in_done=%b done_next=%b want 00", o_stall_done, o_done_after); end
    endtask

    task automatic test_byte_load();
        do_access(1'b0, 32'h103, M_BYTE, 32'h0, 0, 32'h8000_0000);
        n_tests++; if (o_be !== 4'b1000 || o_addr !== 32'h100) begin n_fail++;
            $display("FAIL byte_bus: be=%b addr=%h want 1000 100", o_be, o_addr); end
        n_tests++; if (o_done !== 1'b1 || o_rdata !== 32'hFFFF_FF80) begin n_fail++;
            $display("FAIL byte_signed: done=%b rdata=%h want 1 ffffff80", o_done, o_rdata); end
        do_access(1'b0, 32'h103, M_BYTE_U, 32'h0, 0, 32'h8000_0000);
        n_tests++; if (o_done !== 1'b1 || o_rdata !== 32'h0000_0080) begin n_fail++;
            $display("FAIL byte_unsigned: done=%b rdata=%h want 1 00000080", o_done, o_rdata); end
        do_access(1'b0, 32'h102, M_HALF, 32'h0, 0, 32'h9ABC_0000);
        n_tests++; if (o_be !== 4'b1100 || o_rdata !== 32'hFFFF_9ABC) begin n_fail++;
            $display("FAIL half_signed: be=%b rdata=%h want 1100 ffff9abc", o_be, o_rdata); end
    endtask

    task automatic test_half_store();
        do_access(1'b1, 32'h202, M_HALF, 32'h1234_ABCD, 3, 32'h7777_7777);
        n_tests++; if (o_addr !== 32'h200 || o_be !== 4'b1100 || o_we !== 1'b1) begin n_fail++;
            $display("FAIL store_bus: addr=%h be=%b we=%b want 200 1100 1", o_addr, o_be, o_we); end
        n_tests++; if (o_wdata !== 32'hABCD_0000) begin n_fail++;
            $display("FAIL store_wdata: got %h want abcd0000", o_wdata); end
        n_tests++; if (o_stable !== 1'b1) begin n_fail++;
            $display("FAIL store_wait_stable: got %b want 1", o_stable); end
        n_tests++; if (o_done !== 1'b1 || o_rdata !== 32'hFFFF_9ABC) begin n_fail++;
            $display("FAIL store_done_rdata: done=%b rdata=%h want 1 ffff9abc", o_done, o_rdata); end
    endtask

    task automatic test_invalid_mode();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h400; l_s_mode = 3'd5;
        @(negedge clk);
        n_tests++; if (stall !== 1'b0 || misalign !== 1'b0) begin n_fail++;
            $display("FAIL invalid_stall: stall=%b misalign=%b want 00", stall, misalign); end
        next_cycle();
        @(negedge clk);
        n_tests++; if (bus32.bus_req !== 1'b0 || done !== 1'b0 || rdata !== 32'hFFFF_9ABC) begin n_fail++;
            $display("FAIL invalid_nop: req=%b done=%b rdata=%h want 0 0 ffff9abc", bus32.bus_req, done, rdata); end
        req_valid = 1'b0;
        next_cycle();
    endtask

    task automatic test_misaligned_word();
`ifdef MEM_ALIGN_CHECK_EN
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h101; l_s_mode = M_WORD;
        @(negedge clk);
        n_tests++; if (misalign !== 1'b1 || stall !== 1'b0) begin n_fail++;
            $display("FAIL misalign_flag: misalign=%b stall=%b want 10", misalign, stall); end
        next_cycle();
        next_cycle();
        n_tests++; if (bus32.bus_req !== 1'b0 || done !== 1'b0) begin n_fail++;
            $display("FAIL misalign_dropped: req=%b done=%b want 00", bus32.bus_req, done); end
        req_valid = 1'b0;
        next_cycle();
`else
        do_access(1'b0, 32'h101, M_WORD, 32'h0, 0, 32'h1122_3344);
        n_tests++; if (o_mis_c0 !== 1'b0 || o_stall_c0 !== 1'b1) begin n_fail++;
            $display("FAIL misalign_flag: misalign=%b stall=%b want 01", o_mis_c0, o_stall_c0); end
        n_tests++; if (o_addr !== 32'h100 || o_be !== 4'hF) begin n_fail++;
            $display("FAIL misalign_bus: addr=%h be=%h want 100 f", o_addr, o_be); end
        n_tests++; if (o_rdata !== 32'h1122_3344) begin n_fail++;
            $display("FAIL misalign_rdata: got %h want 11223344", o_rdata); end
`endif
    endtask

    task automatic test_back_to_back();
        do_access(1'b0, 32'h10, M_WORD, 32'h0, 0, 32'h0102_0304);
        n_tests++; if (o_done !== 1'b1 || o_rdata !== 32'h0102_0304) begin n_fail++;
            $display("FAIL b2b_first: done=%b rdata=%h want 1 01020304", o_done, o_rdata); end
        do_access(1'b0, 32'h11, M_BYTE_U, 32'h0, 0, 32'h0000_AA00);
        n_tests++; if (o_stall_c0 !== 1'b1 || o_be !== 4'b0010) begin n_fail++;
            $display("FAIL b2b_accept: stall=%b be=%b want 1 0010", o_stall_c0, o_be); end
        n_tests++; if (o_done !== 1'b1 || o_rdata !== 32'h0000_00AA) begin n_fail++;
            $display("FAIL b2b_second: done=%b rdata=%h want 1 000000aa", o_done, o_rdata); end
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h300; l_s_mode = M_WORD;
        next_cycle();
        n_tests++; if (bus32.bus_req !== 1'b1) begin n_fail++;
            $display("FAIL rstmid_in_bus: req=%b want 1", bus32.bus_req); end
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (bus32.bus_req !== 1'b0 || stall !== 1'b0) begin n_fail++;
            $display("FAIL rstmid_drop: req=%b stall=%b want 00", bus32.bus_req, stall); end
        bus32.bus_ack = 1'b1; bus32.bus_rdata = 32'h1234_5678;
        next_cycle();
        rst_n = 1'b1;
        bus32.bus_ack = 1'b0;
        next_cycle();
        n_tests++; if (done !== 1'b0 || bus32.bus_req !== 1'b0) begin n_fail++;
            $display("FAIL rstmid_no_done: done=%b req=%b want 00", done, bus32.bus_req); end
        do_access(1'b0, 32'h300, M_WORD, 32'h0, 1, 32'hCAFE_F00D);
        n_tests++; if (o_done !== 1'b1 || o_rdata !== 32'hCAFE_F00D) begin n_fail++;
            $display("FAIL rstmid_recover: done=%b rdata=%h want 1 cafef00d", o_done, o_rdata); end
    endtask

    task automatic test_w64();
        v64 = 1'b1; w64 = 1'b0; a64 = 64'h107; m64 = M_BYTE_U;
        next_cycle();
        n_tests++; if (bus64.bus_be !== 8'h80 || bus64.bus_addr !== 64'h100) begin n_fail++;
            $display("FAIL w64_bus: be=%h addr=%h want 80 100", bus64.bus_be, bus64.bus_addr); end
        bus64.bus_ack = 1'b1; bus64.bus_rdata = 64'hAB00_0000_0000_0000;
        next_cycle();
        bus64.bus_ack = 1'b0; v64 = 1'b0;
        n_tests++; if (done64 !== 1'b1 || rd64 !== 64'hAB) begin n_fail++;
            $display("FAIL w64_rdata: done=%b rdata=%h want 1 ab", done64, rd64); end
        next_cycle();
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; l_s_mode = M_WORD; req_wdata = '0;
        v64 = 1'b0; w64 = 1'b0; a64 = '0; m64 = M_WORD; wd64 = '0;
        bus32.bus_ack = 1'b0; bus32.bus_rdata = '0;
        bus64.bus_ack = 1'b0; bus64.bus_rdata = '0;
        test_reset();
        test_word_load();
        test_byte_load();
        test_half_store();
        test_invalid_mode();
        test_misaligned_word();
        test_back_to_back();
        test_reset_mid();
        test_w64();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised memory-stage access unit that replaces the fixed-width load/store forwarder in the MEM stage. It accepts one load or store per request from the pipeline and performs byte-lane alignment, byte enables and sign/zero extension for any data width that is a multiple of 8. It runs a request/acknowledge handshake with a variable-latency data bus and stalls the pipeline until the bus acknowledges.

## Interface
- W, 32: data and address width; multiple of 8, at least 16.
- BYTES, W/8: byte lanes; derived, do not override.
- OFFW, log2(BYTES): width of the byte-offset field; derived.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  the pipeline presents a memory request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  W  byte address.
- l_s_mode  in  3  0 WORD (full W), 1 HALF, 2 HALF_U, 3 BYTE, 4 BYTE_U; codes 5–7 are invalid.
- req_wdata  in  W  store data, right-justified.
- stall  out  1  holds the pipeline; request inputs must stay stable while this is high.
- done  out  1  one-cycle completion pulse.
- rdata  out  W  extended load data.
- misalign  out  1  alignment fault (only exists in the check build; see Configuration).
- bus_req  out  1  bus request.
- bus_we  out  1  bus write enable.
- bus_addr  out  W  word-aligned address; the low OFFW bits are 0.
- bus_be  out  BYTES  byte enables.
- bus_wdata  out  W  lane-shifted store data.
- bus_ack  in  1  bus accepts the write or returns read data this cycle.
- bus_rdata  in  W  read data, valid when bus_ack is high.

## Operation
- **FSM states:** IDLE, BUS, DONE.
- **IDLE, accept:** on req_valid with a valid mode and no fault, go to BUS.
  - Register bus_we, the bus_addr word address, bus_be, bus_wdata, the offset and the mode.
- **BUS:** hold bus_req=1 and every bus_* output stable until bus_ack.
  - On bus_ack, capture the extended read data (loads only) and go to DONE.
  - bus_ack sampled outside BUS is ignored.
- **DONE:** done=1 for one cycle, then return to IDLE. Request inputs are ignored in DONE.
- **Offset:** off = req_addr[OFFW-1:0].
- **Byte enables:**
  - BYTE and BYTE_U: bus_be = 1<<off.
  - HALF and HALF_U: bus_be = 3<<off.
  - WORD: all ones.
- **Store data:** bus_wdata = req_wdata shifted left by off*8; lanes not enabled are 0.
- **Load data:** shift bus_rdata right by off*8, then extend.
  - HALF and BYTE sign-extend from bit 15 and bit 7.
  - HALF_U and BYTE_U zero-extend.
  - WORD passes the data through.
  - rdata holds its value until the next load completes; stores never change it.
- **Invalid mode in IDLE:** no bus access, stall=0, done=0, rdata unchanged.
- **stall:** = (IDLE && req_valid && valid mode && !fault) || BUS. It is combinational; it is low in DONE so the pipeline advances.
- **Reset values:** state IDLE; stall, done, misalign, bus_req, bus_we 0; bus_addr, bus_be, bus_wdata, rdata 0.
- **Reset mid-transaction:** bus_req drops immediately, the access is abandoned, and no done is produced.

## Timing
- **Accept cycle (C0):** the request is accepted in C0 with stall=1.
- **Bus request:** bus_req is high from C1.
- **Completion:** if bus_ack arrives in cycle Cn (n ≥ 1), done=1 in Cn+1 and rdata is valid in Cn+1.
- **Minimum latency:** 2 cycles of stall, done in C2.
- **Next request:** a new request can be accepted the cycle after DONE.
- **Back-to-back throughput:** one access per 3 cycles with a zero-wait bus.
- **Wait states:** unlimited. Stall is held for as long as bus_ack stays low; there is no timeout.

## Configuration
- `MEM_ALIGN_CHECK_EN` **defined:**
  - A request in IDLE is a fault if it is HALF or HALF_U with off[0]≠0, or WORD with off≠0.
  - A fault drives misalign=1 combinationally in that cycle.
  - The request is dropped: no bus access, stall=0, done=0.
- `MEM_ALIGN_CHECK_EN` **undefined:**
  - misalign is tied to 0.
  - Misaligned requests proceed. bus_be and the shifts use the truncated result (enables shifted past the top lane are dropped), and WORD ignores off entirely.

## Test plan
- **Word load, zero wait** (W=32): load, WORD, addr 0x100, bus_ack in C1 with bus_rdata 0xDEADBEEF → bus_addr 0x100, bus_be 4'b1111, done in C2, rdata 0xDEADBEEF, stall high C0–C1.
- **Signed byte load:** load, BYTE, addr 0x103, bus_rdata 0x80000000 → bus_be 4'b1000, rdata 0xFFFFFF80. Repeat with BYTE_U → rdata 0x00000080.
- **Half store with wait states:** store, HALF, addr 0x202, req_wdata 0x1234ABCD, bus_ack held off 3 cycles → bus_addr 0x200, bus_be 4'b1100, bus_wdata 0xABCD0000, all bus outputs stable while waiting, done 5 cycles after accept, rdata unchanged.
- **Misaligned word with `MEM_ALIGN_CHECK_EN`:** WORD load at 0x101 → misalign=1 and stall=0 in the same cycle, bus_req never rises. Without the macro → bus_addr 0x100, be 4'b1111.
- **Reset mid-transaction:** rst_n low while in BUS → bus_req 0 immediately, no done; after release, a new load completes normally.
- **W=64 build:** BYTE_U load at 0x...07, bus_rdata 0xAB00000000000000 → bus_be 8'h80, rdata 0xAB.
